// File: rtl/window3x3_stream_if.sv
// Stream bundle for window3x3_stream: raster pixel input and 3x3 window output.
//
// Handshake (both channels): a transfer happens on a rising clock edge where
// valid and ready are both high. A producer holding valid high keeps its data
// stable until the transfer. Ready may depend on the consumer's own state but
// never combinationally on the producer's valid.
interface window3x3_stream_if #(
  parameter int DATA_W = 8,
  parameter int XW     = 9,
  parameter int YW     = 8
);
  logic                  pix_valid_i;
  logic [DATA_W-1:0]     pix_i;
  logic                  pix_ready_o;
  logic                  win_valid_o;
  logic                  win_ready_i;
  logic [9*DATA_W-1:0]   win_o;
  logic [XW-1:0]         win_x_o;
  logic [YW-1:0]         win_y_o;

  // Window generator side.
  modport slave (
    input  pix_valid_i, pix_i, win_ready_i,
    output pix_ready_o, win_valid_o, win_o, win_x_o, win_y_o
  );

  // Pixel source / window sink side.
  modport master (
    output pix_valid_i, pix_i, win_ready_i,
    input  pix_ready_o, win_valid_o, win_o, win_x_o, win_y_o
  );
endinterface

// File: rtl/window3x3_stream.sv
// window3x3_stream: streaming 3x3 neighbourhood generator with two line buffers.
// Each accepted pixel completes the right-hand column of the window centred
// one row up and one column left of it; that window is registered on the same
// edge. In padded mode a FLUSH phase feeds virtual pixels to finish the last row.
module window3x3_stream #(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int PAD_MODE = 0,
  parameter int XW       = $clog2(IMG_W),
  parameter int YW       = $clog2(IMG_H)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  window3x3_stream_if.slave strm,
  output logic              frame_done_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_PEN  = YW'(IMG_H - 2);

  state_t                   state_q, state_d;
  logic [XW-1:0]            in_x_q;
  logic [YW-1:0]            in_y_q;
  logic                     last_q;
  logic [2:0][DATA_W-1:0]   col_l_q, col_m_q, col_r;
  logic [DATA_W-1:0]        lb0 [IMG_W];
  logic [DATA_W-1:0]        lb1 [IMG_W];

  logic                     out_free, step, emit, abort, primed, interior;
  logic                     in_last, flush_last, out_hs;
  logic [XW-1:0]            cx;
  logic [YW-1:0]            cy;
  logic [DATA_W-1:0]        tap;
  logic [9*DATA_W-1:0]      win_d;

  assign out_free   = !strm.win_valid_o || strm.win_ready_i;
  assign out_hs     = strm.win_valid_o && strm.win_ready_i;
  assign abort      = (state_q == ST_RUN || state_q == ST_FLUSH) && !en_i;
  assign in_last    = (in_x_q == X_LAST) && (in_y_q == Y_LAST);
  assign flush_last = (in_x_q == '0) && (in_y_q == YW'(1));

  // Input is taken only while running, the output register can take a new
  // window, and the final window has not been produced yet.
  assign strm.pix_ready_o = (state_q == ST_RUN) && out_free && !last_q;

  // One raster step: a real accepted pixel in RUN, a virtual zero pixel in FLUSH.
  assign step = (state_q == ST_RUN)   ? (strm.pix_ready_o && strm.pix_valid_i) :
                (state_q == ST_FLUSH) ? (out_free && !last_q) : 1'b0;

  assign frame_done_o = (state_q == ST_DONE);
  assign state_o      = state_q;

  // Newest column: two rows from the line buffers plus the incoming pixel.
  assign col_r[0] = lb1[in_x_q];
  assign col_r[1] = lb0[in_x_q];
  assign col_r[2] = (state_q == ST_FLUSH) ? '0 : strm.pix_i;

  // Centre coordinate: input position minus (1,1), wrapping modulo the frame.
  always_comb begin
    if (in_x_q == '0) begin
      cx = X_LAST;
      cy = (in_y_q >= YW'(2)) ? in_y_q - YW'(2) : in_y_q + Y_PEN;
    end else begin
      cx = in_x_q - XW'(1);
      cy = (in_y_q != '0) ? in_y_q - YW'(1) : Y_LAST;
    end
  end

  // Decide whether this step produces a window.
  always_comb begin
    primed   = (state_q == ST_FLUSH) || (in_y_q >= YW'(2)) ||
               ((in_y_q == YW'(1)) && (in_x_q != '0));
    interior = (cx != '0) && (cx != X_LAST) && (cy != '0) && (cy != Y_LAST);
    emit     = step && primed && ((PAD_MODE != 0) || interior);
  end

  // Assemble taps; anything outside the image (including wrapped columns) is 0.
  always_comb begin
    tap   = '0;
    win_d = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 0)      tap = col_l_q[r];
        else if (c == 1) tap = col_m_q[r];
        else             tap = col_r[r];
        if ((r == 0 && cy == '0) || (r == 2 && cy == Y_LAST) ||
            (c == 0 && cx == '0) || (c == 2 && cx == X_LAST))
          tap = '0;
        win_d[(3*r+c)*DATA_W +: DATA_W] = tap;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (en_i) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)                                      state_d = ST_IDLE;
        else if (last_q && out_hs)                      state_d = ST_DONE;
        else if ((PAD_MODE != 0) && step && in_last)    state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (abort)                 state_d = ST_IDLE;
        else if (last_q && out_hs) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Raster counters, column shift registers and the final-window flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_x_q  <= '0;
      in_y_q  <= '0;
      last_q  <= 1'b0;
      col_l_q <= '0;
      col_m_q <= '0;
    end else if (state_q == ST_IDLE) begin
      in_x_q <= '0;
      in_y_q <= '0;
      last_q <= 1'b0;
    end else if (step) begin
      col_l_q <= col_m_q;
      col_m_q <= col_r;
      in_x_q  <= (in_x_q == X_LAST) ? '0 : in_x_q + XW'(1);
      if (in_x_q == X_LAST) in_y_q <= (in_y_q == Y_LAST) ? '0 : in_y_q + YW'(1);
      if ((state_q == ST_RUN && in_last && PAD_MODE == 0) ||
          (state_q == ST_FLUSH && flush_last))
        last_q <= 1'b1;
    end
  end

  // Line buffers: push the column down one row at the shared write pointer.
  always_ff @(posedge clk_i) begin
    if (step && state_q == ST_RUN) begin
      lb1[in_x_q] <= lb0[in_x_q];
      lb0[in_x_q] <= strm.pix_i;
    end
  end

  // Output register: load on emit, hold while stalled, drop on abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strm.win_valid_o <= 1'b0;
      strm.win_o       <= '0;
      strm.win_x_o     <= '0;
      strm.win_y_o     <= '0;
    end else if (abort) begin
      strm.win_valid_o <= 1'b0;
    end else if (emit) begin
      strm.win_valid_o <= 1'b1;
      strm.win_o       <= win_d;
      strm.win_x_o     <= cx;
      strm.win_y_o     <= cy;
    end else if (strm.win_ready_i) begin
      strm.win_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window3x3_stream.sv
// Directed bench for window3x3_stream on a 5x4 image, one DUT per pad mode.
module tb_window3x3_stream;
  localparam int DW   = 8;
  localparam int W    = 5;
  localparam int H    = 4;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);
  localparam int NPIX = W * H;
  localparam int RW   = YW + XW + 9 * DW;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en0 = 1'b0, en1 = 1'b0, pv = 1'b0, wr = 1'b1, sel = 1'b0;
  logic [DW-1:0] px = '0;
  logic          fd0, fd1;
  logic [1:0]    st0, st1;

  window3x3_stream_if #(.DATA_W(DW), .XW(XW), .YW(YW)) if0 ();
  window3x3_stream_if #(.DATA_W(DW), .XW(XW), .YW(YW)) if1 ();

  assign if0.pix_valid_i = pv;
  assign if0.pix_i       = px;
  assign if0.win_ready_i = wr;
  assign if1.pix_valid_i = pv;
  assign if1.pix_i       = px;
  assign if1.win_ready_i = wr;

  window3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .PAD_MODE(0)) u_pad0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en0), .strm(if0),
    .frame_done_o(fd0), .state_o(st0)
  );
  window3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .PAD_MODE(1)) u_pad1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en1), .strm(if1),
    .frame_done_o(fd1), .state_o(st1)
  );

  // Outputs of whichever DUT is under test.
  logic            s_pr, s_valid, s_fd;
  logic [9*DW-1:0] s_win;
  logic [XW-1:0]   s_x;
  logic [YW-1:0]   s_y;
  logic [1:0]      s_st;
  logic [RW-1:0]   s_rec;
  assign s_pr    = sel ? if1.pix_ready_o : if0.pix_ready_o;
  assign s_valid = sel ? if1.win_valid_o : if0.win_valid_o;
  assign s_win   = sel ? if1.win_o       : if0.win_o;
  assign s_x     = sel ? if1.win_x_o     : if0.win_x_o;
  assign s_y     = sel ? if1.win_y_o     : if0.win_y_o;
  assign s_fd    = sel ? fd1 : fd0;
  assign s_st    = sel ? st1 : st0;
  assign s_rec   = {s_y, s_x, s_win};

  // Scoreboard state.
  logic [DW-1:0] img [NPIX];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] cap_q[$];
  logic          cap_pr[$];
  int n_vec = 0, n_err = 0;
  int cyc_cnt = 0, fd_cnt = 0, first_valid_cyc = -1, acc_cyc = -1, lat_idx = 0;

  always @(posedge clk) cyc_cnt++;

  // Capture every handshaked window of the selected DUT.
  always @(negedge clk) begin
    if (s_valid && wr) begin
      cap_q.push_back(s_rec);
      cap_pr.push_back(s_pr);
    end
    if (s_fd) fd_cnt++;
    if (s_valid && first_valid_cyc < 0) first_valid_cyc = cyc_cnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] get_cap(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return 'x;
  endfunction

  function automatic logic get_pr(input int i);
    if (i < cap_pr.size()) return cap_pr[i];
    return 1'bx;
  endfunction

  function automatic logic [9*DW-1:0] taps9(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
    return {DW'(t8), DW'(t7), DW'(t6), DW'(t5), DW'(t4), DW'(t3), DW'(t2), DW'(t1), DW'(t0)};
  endfunction

  // Reference window straight from the image with zero outside the frame.
  function automatic logic [RW-1:0] model_win(input int x, input int y);
    logic [9*DW-1:0] w;
    int xx, yy;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        xx = x + c - 1;
        yy = y + r - 1;
        if (xx >= 0 && xx < W && yy >= 0 && yy < H) w[(3*r+c)*DW +: DW] = img[yy*W + xx];
      end
    end
    return {YW'(y), XW'(x), w};
  endfunction

  task automatic build_exp(input bit pad);
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (pad || (x >= 1 && x <= W - 2 && y >= 1 && y <= H - 2)) exp_q.push_back(model_win(x, y));
  endtask

  task automatic fill_raster();
    for (int i = 0; i < NPIX; i++) img[i] = DW'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom_range(0, 255));
  endtask

  // Driver: one whole frame, optional input bubbles and a 3-cycle output stall.
  task automatic drive_frame(input bit dsel, input bit bubbles, input int stall_at);
    int idx = 0, cyc = 0, stall_left = 0;
    bit stalled = 0, done = 0;
    @(posedge clk); #1;
    sel = dsel;
    cap_q.delete();
    cap_pr.delete();
    fd_cnt = 0;
    first_valid_cyc = -1;
    acc_cyc = -1;
    if (dsel) en1 = 1'b1; else en0 = 1'b1;
    while (!done && cyc < 400) begin
      pv = (idx < NPIX) && (!bubbles || ($urandom_range(0, 1) == 1));
      px = (idx < NPIX) ? img[idx] : '0;
      if (stall_left > 0) wr = 1'b0;
      else if (stall_at >= 0 && !stalled && s_valid && cap_q.size() == stall_at) begin
        stalled = 1;
        stall_left = 3;
        wr = 1'b0;
      end else wr = 1'b1;
      @(negedge clk);
      if (stall_left > 0) begin
        check("stall_window_held", s_rec, exp_q[stall_at]);
        check("stall_valid_held", s_valid, 1'b1);
        check("stall_pix_ready", s_pr, 1'b0);
        stall_left--;
      end
      if (pv && s_pr) begin
        if (idx == lat_idx) acc_cyc = cyc_cnt;
        idx++;
      end
      if (s_fd) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    pv = 1'b0;
    wr = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    check("frame_done_seen", done, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    foreach (exp_q[i]) check($sformatf("%s_win%0d", tag, i), get_cap(i), exp_q[i]);
    check({tag, "_done_pulses"}, fd_cnt, 1);
  endtask

  task automatic check_rec(input string tag, input int i, input int x, input int y, input logic [9*DW-1:0] w);
    logic [RW-1:0] r;
    r = get_cap(i);
    check({tag, "_taps"}, r[9*DW-1:0], w);
    check({tag, "_x"}, r[9*DW +: XW], x);
    check({tag, "_y"}, r[9*DW+XW +: YW], y);
  endtask

  // Drop enable after n_acc pixels with a window pending on the padded DUT.
  task automatic abort_frame(input int n_acc);
    int idx = 0, cyc = 0;
    @(posedge clk); #1;
    sel = 1'b1;
    cap_q.delete();
    cap_pr.delete();
    fd_cnt = 0;
    en1 = 1'b1;
    wr = 1'b1;
    while (idx < n_acc && cyc < 100) begin
      pv = 1'b1;
      px = img[idx];
      @(negedge clk);
      if (s_pr) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    pv = 1'b0;
    wr = 1'b0;
    en1 = 1'b0;
    check("abort_pixels_taken", idx, n_acc);
    @(negedge clk);
    check("abort_pending_valid", s_valid, 1'b1);
    check("abort_pre_state_run", s_st, 2'd1);
    @(negedge clk);
    check("abort_state_idle", s_st, 2'd0);
    check("abort_valid_cleared", s_valid, 1'b0);
    check("abort_pix_ready", s_pr, 1'b0);
    repeat (4) @(negedge clk);
    check("abort_no_done_pulse", fd_cnt, 0);
    wr = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pix_ready"}, s_pr, 1'b0);
    check({tag, "_win_valid"}, s_valid, 1'b0);
    check({tag, "_win"}, s_win, '0);
    check({tag, "_win_x"}, s_x, '0);
    check({tag, "_win_y"}, s_y, '0);
    check({tag, "_frame_done"}, s_fd, 1'b0);
    check({tag, "_state"}, s_st, 2'd0);
  endtask

  initial begin
    // Reset values of both DUTs.
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    #1 check_idle_outputs("reset_pad0");
    sel = 1'b1;
    #1 check_idle_outputs("reset_pad1");
    rst_n = 1'b1;

    // Interior windows, raster-index pixels, no stalls.
    fill_raster();
    build_exp(1'b0);
    lat_idx = 12;
    drive_frame(1'b0, 1'b0, -1);
    check_frame("pad0_raster");
    check_rec("pad0_first", 0, 1, 1, taps9(0, 1, 2, 5, 6, 7, 10, 11, 12));
    check_rec("pad0_last", 5, 3, 2, taps9(7, 8, 9, 12, 13, 14, 17, 18, 19));
    check("pad0_latency", first_valid_cyc - acc_cyc, 1);

    // Zero-padded full frame.
    build_exp(1'b1);
    lat_idx = 6;
    drive_frame(1'b1, 1'b0, -1);
    check_frame("pad1_raster");
    check_rec("pad1_origin", 0, 0, 0, taps9(0, 0, 0, 0, 0, 1, 0, 5, 6));
    check_rec("pad1_corner", 19, 4, 3, taps9(13, 14, 0, 18, 19, 0, 0, 0, 0));
    check("pad1_latency", first_valid_cyc - acc_cyc, 1);
    for (int i = 14; i < 20; i++) check($sformatf("pad1_flush_pix_ready%0d", i), get_pr(i), 1'b0);

    // Random pixels with a mid-frame output stall.
    fill_random();
    build_exp(1'b0);
    drive_frame(1'b0, 1'b0, 2);
    check_frame("pad0_stall");

    // Same image with input bubbles.
    drive_frame(1'b0, 1'b1, -1);
    check_frame("pad0_bubbles");

    // Padded mode with bubbles and a stall during the flush phase.
    build_exp(1'b1);
    drive_frame(1'b1, 1'b1, 15);
    check_frame("pad1_bubble_stall");

    // Abort after ten pixels, then a clean frame.
    fill_raster();
    abort_frame(10);
    build_exp(1'b1);
    drive_frame(1'b1, 1'b0, -1);
    check_frame("pad1_restart");
    check_rec("pad1_restart_origin", 0, 0, 0, taps9(0, 0, 0, 0, 0, 1, 0, 5, 6));

    // Asynchronous reset while a window is pending.
    @(posedge clk); #1;
    sel = 1'b0;
    en0 = 1'b1;
    wr = 1'b0;
    begin
      int idx = 0, cyc = 0;
      while (!s_valid && cyc < 60) begin
        pv = (idx < NPIX);
        px = img[idx % NPIX];
        @(negedge clk);
        if (pv && s_pr) idx++;
        if (!s_valid) begin
          @(posedge clk); #1;
        end
        cyc++;
      end
    end
    check("rst_pending_valid", s_valid, 1'b1);
    check("rst_pending_x", s_x, 1);
    rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    pv = 1'b0;
    en0 = 1'b0;
    wr = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame after reset recovers normally.
    build_exp(1'b0);
    lat_idx = 12;
    drive_frame(1'b0, 1'b0, -1);
    check_frame("pad0_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
